grey_statis_accum: RTL
======================

# grey_statis_accum

Frame-level grey statistics accumulator placed directly downstream of the AOI window selector in the grey statistics path. It consumes the selector's delayed frame valid, AOI-gated line valid, pixel data and interrupt-enable. It sums every pixel inside the AOI across all channels and counts those pixels. At frame end it stores the totals; on the interrupt-pin rising edge it latches them to the firmware-visible result ports.

## Interface
- SENSOR_DAT_WIDTH, 10, bits per pixel per channel
- CHANNEL_NUM, 4, pixels per clock (power of two, 1–16)
- GREY_STATIS_WIDTH, 48, accumulator and sum-output width
- GREY_CNT_WIDTH, 32, pixel-count width
- Port list:
  - clk  in  1  pixel clock; the block's only clock
  - reset  in  1  synchronous, active-high reset
  - i_fval  in  1  frame valid (selector output)
  - i_lval  in  1  AOI line valid, aligned with iv_pix_data
  - iv_pix_data  in  SENSOR_DAT_WIDTH*CHANNEL_NUM  pixel data; channel 0 is in the LSBs
  - i_interrupt_en  in  1  selector's frame-statistics-valid flag
  - i_interrupt_pin  in  1  interrupt line from the interrupt module
  - ov_grey_statis_sum  out  GREY_STATIS_WIDTH  latched grey sum
  - ov_grey_statis_cnt  out  GREY_CNT_WIDTH  latched pixel count
  - o_statis_done  out  1  one-cycle pulse when frame totals are stored

## Operation
- Stage 1: a registered adder tree sums the CHANNEL_NUM channels. The result is SENSOR_DAT_WIDTH+log2(CHANNEL_NUM) bits wide. lval is delayed with it.
- Stage 2: in ACCUM, each delayed lval=1 cycle adds the channel sum to acc_sum and adds CHANNEL_NUM to acc_cnt.
- Both accumulators saturate at all-ones and never wrap.
- FSM states:
  - IDLE: acc_sum and acc_cnt are held at 0. Go to ACCUM on an i_fval rising edge (i_fval=1 and fval_dly=0).
  - ACCUM: go to FLUSH on an i_fval falling edge.
  - FLUSH: lasts 2 cycles to drain the pipeline; accumulation continues during these cycles. Then go to STORE.
  - STORE: lasts 1 cycle. If i_interrupt_en=1, copy acc_sum/acc_cnt into done_sum/done_cnt and pulse o_statis_done. If i_interrupt_en=0, the done registers keep their old values and there is no pulse. Then go to IDLE.
- A frame whose fval rising edge falls during FLUSH or STORE is skipped entirely: no accumulation and no store. The FSM waits in IDLE for the next rising edge.
- Output latch: on an i_interrupt_pin rising edge, ov_grey_statis_sum ← done_sum and ov_grey_statis_cnt ← done_cnt.
- Pixel data is treated as unsigned. Widths are zero-extended before every add.

## Timing
- Reset clears FSM (to IDLE), acc_*, done_*, outputs, edge registers and pipeline registers; every output is 0 after reset.
- Reset asserted mid-frame discards the partial frame. After reset releases, a frame already in progress (i_fval=1, no rising edge seen) is not accumulated.
- Pixel at input cycle n is reflected in acc_sum at the end of cycle n+2.
- i_fval sampled low at cycle f (high at f-1): FLUSH covers f+1 and f+2, STORE is at f+3, o_statis_done is high during f+3, and done_* are valid from f+4.
- Interrupt-pin rising edge in the same cycle as STORE: the outputs take the pre-STORE done_* values.
- The output latch has 1 cycle of latency after the pin edge is sampled.
- The interrupt pin is edge-detected with one register, so a level held high produces one latch only.

## Structure
- Shared package grey_statis_pkg holds:
  - clog2 function
  - FSM state encoding (IDLE, ACCUM, FLUSH, STORE)
  - width derivations CHN_SUM_WIDTH = SENSOR_DAT_WIDTH + clog2(CHANNEL_NUM)
- Sub-module grey_chn_adder: parameterised registered adder tree, one pipeline stage, fixed 1-cycle latency.
- Top level contains the FSM, accumulators, done registers, edge detectors and output latch.

## Test plan
- Basic sum: CHANNEL_NUM=4, all pixels 100, 2 AOI lines × 3 lval cycles, i_interrupt_en=1 → STORE sum=2400, cnt=24, o_statis_done pulses at f+3. A pin rising edge then gives ov sum=2400, cnt=24.
- Disabled frame: same frame with i_interrupt_en=0 → no o_statis_done; the ports keep the previous frame's values after a pin edge.
- Saturation: GREY_STATIS_WIDTH=12, pixels 1023 × 4 channels × 2 cycles → sum=4095 (saturated), cnt=8.
- Simultaneous events: pin rising edge in the STORE cycle → ports show the old totals; a second pin edge shows the new ones.
- Reset mid-frame: reset pulse during ACCUM, then i_fval stays high → nothing is stored for that frame; all outputs read 0.
- Short gap: i_fval low for 1 cycle between frames → frame 1 is stored correctly, frame 2 is skipped, and frame 3 accumulates correctly.

Source files
------------

// File: rtl/grey_statis_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | grey_statis_pkg : shared FSM encoding and width helpers              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package grey_statis_pkg;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_ACCUM = 2'd1;
  localparam logic [1:0] c_ST_FLUSH = 2'd2;
  localparam logic [1:0] c_ST_STORE = 2'd3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Width of the per-clock channel sum: SENSOR_DAT_WIDTH + clog2(CHANNEL_NUM)
  function automatic int chn_sum_width(input int dat_w, input int chn_num);
    return dat_w + clog2(chn_num);
  endfunction

endpackage
`default_nettype wire

// File: rtl/grey_chn_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | grey_chn_adder : registered adder tree over all channels, 1 cycle    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module grey_chn_adder
  import grey_statis_pkg::*;
#(
  parameter int SENSOR_DAT_WIDTH = 10,
  parameter int CHANNEL_NUM      = 4,
  parameter int CHN_SUM_WIDTH    = chn_sum_width(SENSOR_DAT_WIDTH, CHANNEL_NUM)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  i_lval,
  input  logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] iv_pix_data,
  output logic                                  o_lval,
  output logic [CHN_SUM_WIDTH-1:0]              ov_chn_sum
);

  localparam int c_NODES = 2 * CHANNEL_NUM - 1;

  // Heap-ordered tree: leaves at [CHANNEL_NUM-1 +: CHANNEL_NUM], root at [0]
  logic [CHN_SUM_WIDTH-1:0] w_tree [c_NODES];

  always_comb begin
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      w_tree[CHANNEL_NUM-1+i] =
        CHN_SUM_WIDTH'(iv_pix_data[i*SENSOR_DAT_WIDTH +: SENSOR_DAT_WIDTH]);
    end
    for (int i = CHANNEL_NUM - 2; i >= 0; i--) begin
      w_tree[i] = w_tree[2*i+1] + w_tree[2*i+2];
    end
  end

  logic                     r_lval;
  logic [CHN_SUM_WIDTH-1:0] r_chn_sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lval    <= 1'b0;
      r_chn_sum <= '0;
    end else begin
      r_lval    <= i_lval;
      r_chn_sum <= w_tree[0];
    end
  end

  assign o_lval     = r_lval;
  assign ov_chn_sum = r_chn_sum;

endmodule
`default_nettype wire

// File: rtl/grey_statis_accum.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | grey_statis_accum : per-frame AOI grey sum / pixel count with latch  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module grey_statis_accum
  import grey_statis_pkg::*;
#(
  parameter int SENSOR_DAT_WIDTH  = 10,
  parameter int CHANNEL_NUM       = 4,
  parameter int GREY_STATIS_WIDTH = 48,
  parameter int GREY_CNT_WIDTH    = 32
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  i_fval,
  input  logic                                  i_lval,
  input  logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] iv_pix_data,
  input  logic                                  i_interrupt_en,
  input  logic                                  i_interrupt_pin,
  output logic [GREY_STATIS_WIDTH-1:0]          ov_grey_statis_sum,
  output logic [GREY_CNT_WIDTH-1:0]             ov_grey_statis_cnt,
  output logic                                  o_statis_done
);

  localparam int c_CHN_SUM_W = chn_sum_width(SENSOR_DAT_WIDTH, CHANNEL_NUM);
  localparam logic [GREY_CNT_WIDTH:0] c_CNT_INC = (GREY_CNT_WIDTH+1)'(CHANNEL_NUM);

  logic                   w_lval_dly;
  logic [c_CHN_SUM_W-1:0] w_chn_sum;

  grey_chn_adder #(
    .SENSOR_DAT_WIDTH (SENSOR_DAT_WIDTH),
    .CHANNEL_NUM      (CHANNEL_NUM),
    .CHN_SUM_WIDTH    (c_CHN_SUM_W)
  ) u_chn_adder (
    .clk         (clk),
    .reset       (reset),
    .i_lval      (i_lval),
    .iv_pix_data (iv_pix_data),
    .o_lval      (w_lval_dly),
    .ov_chn_sum  (w_chn_sum)
  );

  logic [1:0]                   r_state;
  logic                         r_flush_cnt;
  logic                         r_fval_dly;
  logic                         r_fval_armed;
  logic                         r_pin_dly;
  logic [GREY_STATIS_WIDTH-1:0] r_acc_sum;
  logic [GREY_CNT_WIDTH-1:0]    r_acc_cnt;
  logic [GREY_STATIS_WIDTH-1:0] r_done_sum;
  logic [GREY_CNT_WIDTH-1:0]    r_done_cnt;
  logic [GREY_STATIS_WIDTH-1:0] r_out_sum;
  logic [GREY_CNT_WIDTH-1:0]    r_out_cnt;

  // A rise only counts once fval has been seen low, so a frame already
  // running when reset releases is never mistaken for a new frame.
  logic w_fval_rise;
  logic w_fval_fall;
  logic w_pin_rise;
  assign w_fval_rise = i_fval & ~r_fval_dly & r_fval_armed;
  assign w_fval_fall = ~i_fval & r_fval_dly;
  assign w_pin_rise  = i_interrupt_pin & ~r_pin_dly;

  logic                         w_accum_en;
  logic [GREY_STATIS_WIDTH:0]   w_sum_ext;
  logic [GREY_CNT_WIDTH:0]      w_cnt_ext;
  logic [GREY_STATIS_WIDTH-1:0] w_sum_sat;
  logic [GREY_CNT_WIDTH-1:0]    w_cnt_sat;

  assign w_accum_en = w_lval_dly & ((r_state == c_ST_ACCUM) | (r_state == c_ST_FLUSH));
  assign w_sum_ext  = {1'b0, r_acc_sum} + (GREY_STATIS_WIDTH+1)'(w_chn_sum);
  assign w_cnt_ext  = {1'b0, r_acc_cnt} + c_CNT_INC;
  assign w_sum_sat  = w_sum_ext[GREY_STATIS_WIDTH] ? '1 : w_sum_ext[GREY_STATIS_WIDTH-1:0];
  assign w_cnt_sat  = w_cnt_ext[GREY_CNT_WIDTH]    ? '1 : w_cnt_ext[GREY_CNT_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fval_dly   <= 1'b0;
      r_fval_armed <= ~i_fval;
      r_pin_dly    <= 1'b0;
    end else begin
      r_fval_dly <= i_fval;
      r_pin_dly  <= i_interrupt_pin;
      if (!i_fval) r_fval_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= c_ST_IDLE;
      r_flush_cnt <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_fval_rise) r_state <= c_ST_ACCUM;
        end
        c_ST_ACCUM: begin
          r_flush_cnt <= 1'b0;
          if (w_fval_fall) r_state <= c_ST_FLUSH;
        end
        c_ST_FLUSH: begin
          r_flush_cnt <= 1'b1;
          if (r_flush_cnt) r_state <= c_ST_STORE;
        end
        c_ST_STORE: r_state <= c_ST_IDLE;
        default:    r_state <= c_ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc_sum <= '0;
      r_acc_cnt <= '0;
    end else if (w_accum_en) begin
      r_acc_sum <= w_sum_sat;
      r_acc_cnt <= w_cnt_sat;
    end else if ((r_state == c_ST_IDLE) || (r_state == c_ST_STORE)) begin
      r_acc_sum <= '0;
      r_acc_cnt <= '0;
    end
  end

  // The output latch reads the pre-update done value when a pin edge
  // coincides with STORE, since both registers update on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done_sum <= '0;
      r_done_cnt <= '0;
      r_out_sum  <= '0;
      r_out_cnt  <= '0;
    end else begin
      if ((r_state == c_ST_STORE) && i_interrupt_en) begin
        r_done_sum <= r_acc_sum;
        r_done_cnt <= r_acc_cnt;
      end
      if (w_pin_rise) begin
        r_out_sum <= r_done_sum;
        r_out_cnt <= r_done_cnt;
      end
    end
  end

  assign ov_grey_statis_sum = r_out_sum;
  assign ov_grey_statis_cnt = r_out_cnt;
  assign o_statis_done      = (r_state == c_ST_STORE) & i_interrupt_en;

endmodule
`default_nettype wire
